// File: rtl/iir_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : iir_mac_engine
// Purpose  : Time-multiplexed direct-form-I IIR engine: 10 signed MACs per
//            sample, round-half-up, saturate, valid/ready output.
// Revision : 1.0
// ============================================================================
module iir_mac_engine #(
  parameter int DW     = 16,
  parameter int A_FRAC = 13,
  parameter int B_FRAC = 11,
  parameter int ACC_W  = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [14:0]   a_c [0:5],
  input  logic signed [11:0]   b_c [0:3],
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 sat_o
);

  localparam int c_SH = A_FRAC - B_FRAC;
  localparam logic signed [ACC_W-1:0] c_HALF = ACC_W'(1) <<< (A_FRAC - 1);
  localparam logic signed [ACC_W-1:0] c_YMAX = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] c_YMIN = -(ACC_W'(1) <<< (DW - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [3:0]               r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DW-1:0]     r_x [0:3];
  logic signed [DW-1:0]     r_y [0:5];

  logic [1:0]               w_bidx;
  logic [2:0]               w_aidx;
  logic signed [DW+11:0]    w_bprod;
  logic signed [DW+14:0]    w_aprod;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic                     w_hi;
  logic                     w_lo;
  logic signed [DW-1:0]     w_y;

  // Taps 0..3 walk the x line with b0..b3, taps 4..9 walk the y line with a1..a6.
  assign w_bidx  = r_tap[1:0];
  assign w_aidx  = (r_tap >= 4'd4) ? 3'(r_tap - 4'd4) : 3'd0;
  assign w_bprod = b_c[w_bidx] * r_x[w_bidx];
  assign w_aprod = a_c[w_aidx] * r_y[w_aidx];
  assign w_term  = (r_tap < 4'd4) ? (ACC_W'(w_bprod) <<< c_SH) : ACC_W'(w_aprod);

  assign w_sum = r_acc + c_HALF;
  assign w_rnd = w_sum >>> A_FRAC;
  assign w_hi  = (w_rnd > c_YMAX);
  assign w_lo  = (w_rnd < c_YMIN);
  assign w_y   = w_hi ? c_YMAX[DW-1:0] : (w_lo ? c_YMIN[DW-1:0] : w_rnd[DW-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_acc   <= '0;
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
      for (int i = 0; i < 6; i++) r_y[i] <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      sat_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            for (int i = 3; i > 0; i--) r_x[i] <= r_x[i-1];
            r_x[0]  <= s_data;
            r_acc   <= '0;
            r_tap   <= '0;
            s_ready <= 1'b0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_term;
          r_tap <= r_tap + 4'd1;
          // >= rather than == so a corrupted counter still leaves MAC
          if (r_tap >= 4'd9) r_state <= S_ROUND;
        end
        S_ROUND: begin
          m_data  <= w_y;
          sat_o   <= w_hi | w_lo;
          m_valid <= 1'b1;
          for (int i = 5; i > 0; i--) r_y[i] <= r_y[i-1];
          r_y[0]  <= w_y;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_mac_engine.sv
`default_nettype none
// Self-checking bench for iir_mac_engine: directed vector table, hand-written
// corner sequences, and a scoreboard fed by a difference-equation model.
module tb_iir_mac_engine;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [14:0] a_c [0:5];
  logic signed [11:0] b_c [0:3];
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               sat_o;

  iir_mac_engine #(.DW(16), .A_FRAC(13), .B_FRAC(11), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .a_c(a_c), .b_c(b_c),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: the difference equation ----------------
  int  xh [0:3];
  int  yh [0:5];
  int  exp_y [$];
  bit  exp_s [$];
  int  out_log [$];
  bit  sat_log [$];
  int  ref1 [$];
  int  acc_edge = 0;
  bit  prev_mv = 0, prev_hs = 0;
  logic signed [15:0] prev_data = '0;
  bit  b2b = 0, b2b_first = 0;

  function automatic void model_step(input int x, output int y, output bit s);
    longint acc, r, q;
    for (int k = 3; k > 0; k--) xh[k] = xh[k-1];
    xh[0] = x;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += longint'(b_c[k]) * xh[k] * 4;
    for (int k = 0; k < 6; k++) acc += longint'(a_c[k]) * yh[k];
    r = acc + 4096;
    q = r / 8192;
    if (r < 0 && q * 8192 != r) q = q - 1;
    s = 1'b0;
    if (q > 32767) begin q = 32767; s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    y = int'(q);
    for (int k = 5; k > 0; k--) yh[k] = yh[k-1];
    yh[0] = y;
  endfunction

  always @(negedge clk) begin
    int y;
    bit s;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) xh[k] = 0;
      for (int k = 0; k < 6; k++) yh[k] = 0;
      exp_y.delete();
      exp_s.delete();
      prev_mv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (m_valid && !prev_mv) chk("latency", cyc - acc_edge, 11);
      if (prev_mv && !prev_hs) begin
        chk("mvalid_held", m_valid, 1);
        chk("mdata_stable", m_data, prev_data);
      end
      if (m_valid) chk("sready_busy", s_ready, 0);
      if (m_valid && m_ready) begin
        if (exp_y.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          y = exp_y.pop_front();
          s = exp_s.pop_front();
          chk("m_data", m_data, y);
          chk("sat_o", sat_o, s);
        end
        out_log.push_back(int'(m_data));
        sat_log.push_back(sat_o);
      end
      if (s_valid && s_ready) begin
        if (b2b && !b2b_first) chk("b2b_spacing", cyc + 1 - acc_edge, 13);
        if (b2b) b2b_first = 1'b0;
        acc_edge = cyc + 1;
        model_step(int'(s_data), y, s);
        exp_y.push_back(y);
        exp_s.push_back(s);
      end
      prev_mv   = m_valid;
      prev_hs   = m_valid && m_ready;
      prev_data = m_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] x);
    int n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    if (!s_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    s_valid = 1'b1;
    s_data  = x;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(s_ready && !m_valid) && n < 200) begin tick(); n++; end
    if (!(s_ready && !m_valid)) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid && n < 40) begin tick(); n++; end
    if (!m_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic do_reset(input bit check);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    repeat (3) tick();
    if (check) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_sat_o", sat_o, 0);
      chk("rst_s_ready", s_ready, 0);
    end
    rst_n = 1'b1;
    tick();
    if (check) chk("rel_s_ready", s_ready, 1);
  endtask

  task automatic team_coefs();
    b_c = '{12'sd9, 12'sd27, 12'sd27, 12'sd9};
    a_c = '{15'sd4000, -15'sd2000, 15'sd800, -15'sd300, 15'sd100, -15'sd30};
  endtask

  typedef struct {
    logic signed [11:0] b0;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               sat;
  } vec_t;
  vec_t vecs [11];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt, guard, bad_v, bad_d, bad_r, saw_mv;
    logic signed [15:0] hold;

    vecs[0]  = '{12'sd1,     16'sd1024,   16'sd1,      1'b0};
    vecs[1]  = '{12'sd1,    -16'sd1024,   16'sd0,      1'b0};
    vecs[2]  = '{12'sd1,     16'sd1023,   16'sd0,      1'b0};
    vecs[3]  = '{12'sd1,    -16'sd1025,  -16'sd1,      1'b0};
    vecs[4]  = '{12'sd9,     16'sd32767,  16'sd144,    1'b0};
    vecs[5]  = '{12'sh7FF,   16'sd32767,  16'sd32751,  1'b0};
    vecs[6]  = '{12'sh7FF,  -16'sd32768, -16'sd32752,  1'b0};
    vecs[7]  = '{-12'sd2048, -16'sd32768, 16'sd32767,  1'b1};
    vecs[8]  = '{-12'sd2048, 16'sd32767, -16'sd32767,  1'b0};
    vecs[9]  = '{12'sd0,     16'sd12345,  16'sd0,      1'b0};
    vecs[10] = '{12'sd1,    -16'sd1023,   16'sd0,      1'b0};

    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    team_coefs();

    // Reset state, then impulse through the team filter
    do_reset(1'b1);
    out_log.delete();
    sat_log.delete();
    send(16'sd32767);
    for (int i = 1; i < 64; i++) send(16'sd0);
    wait_idle();
    chk("imp_count", out_log.size(), 64);
    if (out_log.size() > 0) begin
      chk("imp_first", out_log[0], 144);
      chk("imp_first_sat", sat_log[0], 0);
    end
    ref1 = out_log;

    // Backpressure: output held, inputs ignored
    m_ready = 1'b0;
    send(16'(int'($urandom_range(0, 40000)) - 20000));
    wait_valid();
    hold = m_data;
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      tick();
      if (!m_valid) bad_v++;
      if (m_data != hold) bad_d++;
      if (s_ready) bad_r++;
    end
    chk("bp_valid_drops", bad_v, 0);
    chk("bp_data_changes", bad_d, 0);
    chk("bp_sready_high", bad_r, 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("bp_mvalid_after", m_valid, 0);
    chk("bp_sready_after", s_ready, 1);

    // Single-sample directed vectors from a clean history
    foreach (vecs[i]) begin
      do_reset(1'b0);
      b_c = '{vecs[i].b0, 12'sd0, 12'sd0, 12'sd0};
      a_c = '{15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0};
      send(vecs[i].x);
      wait_valid();
      chk($sformatf("vec%0d_y", i), m_data, vecs[i].y);
      chk($sformatf("vec%0d_sat", i), sat_o, vecs[i].sat);
      wait_idle();
    end

    // Saturating step, positive then negative
    do_reset(1'b0);
    b_c = '{12'sh7FF, 12'sh7FF, 12'sh7FF, 12'sh7FF};
    a_c = '{15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0};
    out_log.delete();
    sat_log.delete();
    repeat (6) send(16'sd32767);
    wait_idle();
    chk("satp_count", out_log.size(), 6);
    if (out_log.size() == 6) begin
      chk("satp_y0", out_log[0], 32751);
      chk("satp_s0", sat_log[0], 0);
      chk("satp_y1", out_log[1], 32767);
      chk("satp_s1", sat_log[1], 1);
      chk("satp_y5", out_log[5], 32767);
    end
    out_log.delete();
    sat_log.delete();
    repeat (6) send(-16'sd32768);
    wait_idle();
    chk("satn_count", out_log.size(), 6);
    if (out_log.size() == 6) begin
      chk("satn_y5", out_log[5], -32768);
      chk("satn_s5", sat_log[5], 1);
    end

    // Reset during MAC tap 5 aborts the sample and clears history
    team_coefs();
    send(16'sd32767);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_m_valid", m_valid, 0);
    chk("mid_m_data", m_data, 0);
    chk("mid_sat_o", sat_o, 0);
    chk("mid_s_ready", s_ready, 0);
    tick();
    rst_n = 1'b1;
    saw_mv = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (m_valid) saw_mv++;
    end
    chk("mid_no_output", saw_mv, 0);
    out_log.delete();
    send(16'sd32767);
    for (int i = 1; i < 16; i++) send(16'sd0);
    wait_idle();
    chk("mid_count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size() && i < ref1.size(); i++)
      chk($sformatf("mid_repro%0d", i), out_log[i], ref1[i]);

    // Random traffic with random sink stalls
    for (int i = 0; i < 600; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_idle();

    // Back-to-back throughput
    b2b_first = 1'b1;
    b2b = 1'b1;
    s_valid = 1'b1;
    s_data = 16'($urandom);
    cnt = 0;
    guard = 0;
    while (cnt < 100 && guard < 2000) begin
      if (s_ready) begin
        tick();
        cnt++;
        s_data = 16'($urandom);
      end else begin
        tick();
      end
      guard++;
    end
    s_valid = 1'b0;
    b2b = 1'b0;
    chk("b2b_accepts", cnt, 100);
    wait_idle();
    chk("pending_empty", exp_y.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iir_mac_engine.md
# iir_mac_engine

Time-multiplexed direct-form-I IIR datapath that consumes the fixed feedforward (`b_c[0:3]`) and feedback (`a_c[0:5]`) coefficient sets produced by the filter coefficient module. For each accepted input sample it runs one signed multiply-accumulate per tap (10 taps), then rounds and saturates the result. It presents each output over a valid/ready handshake to the downstream sink. It sits directly downstream of the coefficient block and upstream of the sample sink.

## Interface
Parameters:
- `DW`, 16: sample width, signed Q1.(DW-1).
- `A_FRAC`, 13: fractional bits of `a_c` (15-bit signed).
- `B_FRAC`, 11: fractional bits of `b_c` (12-bit signed).
- `ACC_W`, 40: accumulator width, signed.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `a_c`  in  15 x [0:5]  feedback coefficients a1..a6, static.
- `b_c`  in  12 x [0:3]  feedforward coefficients b0..b3, static.
- `s_data`  in  DW  input sample, signed.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  engine can accept a sample.
- `m_data`  out  DW  filtered output, signed.
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  sink accepts output.
- `sat_o`  out  1  the current `m_data` was clipped; valid while `m_valid`.

## Operation
- Difference equation: y[n] = Σ(k=0..3) b_c[k]·x[n-k] + Σ(k=1..6) a_c[k-1]·y[n-k]. The feedback coefficients are stored pre-negated, so every tap is added.
- History: x line holds 4 entries (x[n]..x[n-3]) and y line holds 6 entries (y[n-1]..y[n-6]). All entries reset to 0.
- The x line shifts on the input handshake: new sample goes to x[0] and the oldest entry is dropped.
- The y line shifts in ROUND: the saturated y[n] goes to y[n-1].
- Alignment:
  - b products (frac DW-1+B_FRAC) are shifted left by A_FRAC-B_FRAC (= 2).
  - a products (frac DW-1+A_FRAC) are added unshifted.
  - Accumulator frac = DW-1+A_FRAC; the accumulator is sign-extended to ACC_W.
- Output conversion: add 2^(A_FRAC-1), arithmetic shift right by A_FRAC, then saturate to [-2^(DW-1), 2^(DW-1)-1].
- `sat_o` = 1 iff clipping occurred.
- FSM states:
  - IDLE: `s_ready`=1. On `s_valid`: shift x line, clear accumulator and tap counter, go to MAC.
  - MAC: one tap per cycle; tap counter runs 0..9. Taps 0..3 use b0..b3 × x[0..3]. Taps 4..9 use a1..a6 × y[n-1..n-6]. After tap 9, go to ROUND.
  - ROUND: round and saturate; register `m_data` and `sat_o`; set `m_valid`; shift y line; go to HOLD.
  - HOLD: `m_valid`=1; `m_data` and `sat_o` are stable. When `m_ready`=1, clear `m_valid` and go to IDLE.
- `s_ready` is asserted only in IDLE. No input is accepted in MAC, ROUND or HOLD, even if the sink is ready in the same cycle.
- Reset: FSM goes to IDLE. `m_data`=0, `m_valid`=0, `sat_o`=0, `s_ready`=0 during reset and 1 in the first cycle after release. Accumulator, counter and both history lines are 0.
- Reset asserted in any state aborts the computation. The partial sample is discarded, and its x-line shift is also cleared by the history reset.
- Coefficients are sampled live each MAC cycle. Changing them mid-sample is unsupported; the result is undefined but the FSM must not hang.

## Timing
- Handshake accepted at edge T. MAC runs at edges T+1..T+10. ROUND is at edge T+11, so `m_valid` is high from the cycle after T+11 (latency 11 clocks accept-to-valid).
- The output handshake completes at an edge with `m_valid`&`m_ready`. `s_ready` rises in the following cycle.
- Peak throughput: one sample per 13 clocks when `m_ready` is tied high.
- `m_valid` never drops without a handshake.
- With `m_ready` held low indefinitely: the engine stays in HOLD, `s_ready`=0, and histories are frozen.
- Accumulator: overflow cannot occur at ACC_W=40 for DW=16 with 10 taps. No wrap handling is required.

## Test plan
- Reset then impulse, with the team coefficients, `m_ready`=1. Drive x=32767, then zeros. Required: first `m_data`=144, `sat_o`=0, and `m_valid` rises exactly 11 clocks after the accept. Subsequent outputs match the bit-exact reference model for 64 samples.
- Backpressure: hold `m_ready`=0 for 20 cycles after `m_valid`. Required: `m_data` stable, `s_ready`=0, `s_valid` pulses ignored. Release `m_ready`: `m_valid` drops next cycle, and `s_ready` rises the cycle after the handshake.
- Saturation: set b_c all 12'sh7FF and a_c all 0, then drive a step of 32767. Required: y0=32751 with `sat_o`=0; y1 onward = 32767 with `sat_o`=1. Negative step -32768 gives -32768 with `sat_o`=1.
- Rounding tie: set b0=1 (others 0), x=1024. The product is 1024<<2 = 4096, exactly half an LSB, so the required output is 1. With x=-1024 the required output is 0 (round half up).
- Mid-sample reset: assert `rst_n`=0 at MAC tap 5, then release. Required: no `m_valid`; all outputs 0; and the next impulse reproduces scenario 1 exactly (histories cleared).
- Back-to-back throughput: `s_valid` and `m_ready` held high for 100 samples. Required: accepts exactly 13 clocks apart, and output matches the reference model.
